// File: rtl/pc_sequencer_if.sv
// Handshake/bus bundle between the program test bench and pc_sequencer.
// The master drives the control and branch inputs; the slave (sequencer) drives the status outputs.
interface pc_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 6,
  parameter int unsigned CYC_W = 16
);
  logic             start;
  logic             halt;
  logic             stall;
  logic             br_taken;
  logic             br_abs;
  logic             br_rel;
  logic [PC_W-1:0]  br_target;
  logic [OFF_W-1:0] br_off;
  logic [PC_W-1:0]  prog_ct;
  logic             running;
  logic             done;
  logic [CYC_W-1:0] cyc_cnt;
  logic             wrap_err;

  modport master (
    output start, halt, stall, br_taken, br_abs, br_rel, br_target, br_off,
    input  prog_ct, running, done, cyc_cnt, wrap_err
  );

  modport slave (
    input  start, halt, stall, br_taken, br_abs, br_rel, br_target, br_off,
    output prog_ct, running, done, cyc_cnt, wrap_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start arming, halt/stall, absolute and relative
// branches, sticky wrap detection and a saturating run-cycle counter.
module pc_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned OFF_W      = 6,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CYC_W      = 16
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [PC_W-1:0] START_PC = START_ADDR[PC_W-1:0];
  localparam int unsigned     EXT_W    = PC_W + 1 - OFF_W;

  state_t           state;
  logic             armed;
  logic [PC_W-1:0]  prog_ct;
  logic             running;
  logic             done;
  logic [CYC_W-1:0] cyc_cnt;
  logic             wrap_err;

  logic [PC_W:0]    pc_inc;
  logic [PC_W:0]    off_ext;
  logic [PC_W:0]    pc_rel;

  // One extra MSB on both adds: it is set on carry out of all-ones or on a
  // borrow below zero, which is exactly the wrap condition.
  always_comb begin
    pc_inc  = {1'b0, prog_ct} + {{PC_W{1'b0}}, 1'b1};
    off_ext = {{EXT_W{bus.br_off[OFF_W-1]}}, bus.br_off};
    pc_rel  = {1'b0, prog_ct} + off_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      prog_ct  <= START_PC;
      running  <= 1'b0;
      done     <= 1'b0;
      cyc_cnt  <= '0;
      wrap_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            prog_ct  <= START_PC;
            cyc_cnt  <= '0;
            wrap_err <= 1'b0;
            armed    <= 1'b1;
          end else if (armed) begin
            state   <= RUN;
            running <= 1'b1;
            armed   <= 1'b0;
          end
        end

        RUN: begin
          if (cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
          if (bus.start) begin
            state   <= IDLE;
            running <= 1'b0;
            prog_ct <= START_PC;
            armed   <= 1'b1;
          end else if (bus.halt) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (bus.stall) begin
            prog_ct <= prog_ct;
          end else if (bus.br_taken && bus.br_abs) begin
            prog_ct <= bus.br_target;
          end else if (bus.br_taken && bus.br_rel) begin
            prog_ct <= pc_rel[PC_W-1:0];
            if (pc_rel[PC_W]) begin
              wrap_err <= 1'b1;
            end
          end else begin
            prog_ct <= pc_inc[PC_W-1:0];
            if (pc_inc[PC_W]) begin
              wrap_err <= 1'b1;
            end
          end
        end

        DONE: begin
          if (bus.start) begin
            state    <= IDLE;
            done     <= 1'b0;
            prog_ct  <= START_PC;
            cyc_cnt  <= '0;
            wrap_err <= 1'b0;
            armed    <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_ct  = prog_ct;
  assign bus.running  = running;
  assign bus.done     = done;
  assign bus.cyc_cnt  = cyc_cnt;
  assign bus.wrap_err = wrap_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: integer-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pc_sequencer;

  localparam int PC_W    = 10;
  localparam int OFF_W   = 6;
  localparam int CYC_W   = 16;
  localparam int START   = 0;
  localparam int SPAN    = 1 << PC_W;
  localparam int CYC_MAX = (1 << CYC_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pc_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W), .CYC_W(CYC_W)) bus ();

  pc_sequencer #(
    .PC_W(PC_W),
    .OFF_W(OFF_W),
    .START_ADDR(START),
    .CYC_W(CYC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: mode, arming and integer PC/cycle arithmetic
  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t m_mode  = M_IDLE;
  bit    m_armed = 1'b0;
  int    m_pc    = START;
  int    m_cyc   = 0;
  bit    m_wrap  = 1'b0;

  function automatic int wrap_pc(input int v);
    return ((v % SPAN) + SPAN) % SPAN;
  endfunction

  always @(posedge clk or posedge reset) begin
    int nxt;
    int off;
    if (reset) begin
      m_mode = M_IDLE; m_armed = 1'b0; m_pc = START; m_cyc = 0; m_wrap = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (bus.start) begin
        m_pc = START; m_cyc = 0; m_wrap = 1'b0; m_armed = 1'b1;
      end else if (m_armed) begin
        m_mode = M_RUN; m_armed = 1'b0;
      end
    end else if (m_mode == M_RUN) begin
      m_cyc = (m_cyc < CYC_MAX) ? m_cyc + 1 : CYC_MAX;
      if (bus.start) begin
        m_mode = M_IDLE; m_pc = START; m_armed = 1'b1;
      end else if (bus.halt) begin
        m_mode = M_DONE;
      end else if (!bus.stall) begin
        if (bus.br_taken && bus.br_abs) begin
          m_pc = int'(bus.br_target);
        end else begin
          off = int'($signed(bus.br_off));
          nxt = (bus.br_taken && bus.br_rel) ? m_pc + off : m_pc + 1;
          if (nxt < 0 || nxt >= SPAN) m_wrap = 1'b1;
          m_pc = wrap_pc(nxt);
        end
      end
    end else begin
      if (bus.start) begin
        m_mode = M_IDLE; m_pc = START; m_cyc = 0; m_wrap = 1'b0; m_armed = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("prog_ct",  int'(bus.prog_ct),  m_pc);
      cmp("running",  int'(bus.running),  int'(m_mode == M_RUN));
      cmp("done",     int'(bus.done),     int'(m_mode == M_DONE));
      cmp("cyc_cnt",  int'(bus.cyc_cnt),  m_cyc);
      cmp("wrap_err", int'(bus.wrap_err), int'(m_wrap));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_br();
    bus.br_taken = 1'b0; bus.br_abs = 1'b0; bus.br_rel = 1'b0;
    bus.br_target = '0; bus.br_off = '0; bus.stall = 1'b0; bus.halt = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    clr_br();
    #1 reset = 1'b1;
    #2 cmp_en = 1'b1;
    cmp("rst_pc", int'(bus.prog_ct), 0);
    cmp("rst_running", int'(bus.running), 0);
    cmp("rst_done", int'(bus.done), 0);
    cmp("rst_cyc", int'(bus.cyc_cnt), 0);
    cmp("rst_wrap", int'(bus.wrap_err), 0);
    step(2);
    reset = 1'b0;

    // T6: never armed, so start low keeps it idle
    step(5);
    cmp("t6_pc", int'(bus.prog_ct), 0);
    cmp("t6_running", int'(bus.running), 0);

    // T1: plain run 0..10, halt at 10
    bus.start = 1'b1; step(2);
    bus.start = 1'b0; step(1);
    cmp("t1_running", int'(bus.running), 1);
    cmp("t1_pc0", int'(bus.prog_ct), 0);
    step(10);
    cmp("t1_pc10", int'(bus.prog_ct), 10);
    bus.halt = 1'b1; step(1); bus.halt = 1'b0;
    cmp("t1_done", int'(bus.done), 1);
    cmp("t1_cyc", int'(bus.cyc_cnt), 11);
    bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_abs = 1'b1; bus.br_target = 10'h155;
    step(3); clr_br();
    cmp("t1_hold_pc", int'(bus.prog_ct), 10);
    cmp("t1_hold_cyc", int'(bus.cyc_cnt), 11);

    // T2: absolute then relative branch
    bus.start = 1'b1; step(1);
    cmp("t2_done_clr", int'(bus.done), 0);
    cmp("t2_cyc_clr", int'(bus.cyc_cnt), 0);
    bus.start = 1'b0; step(1);
    step(4);
    cmp("t2_pc4", int'(bus.prog_ct), 4);
    bus.br_taken = 1'b1; bus.br_abs = 1'b1; bus.br_target = 10'h3F0; step(1); clr_br();
    cmp("t2_abs", int'(bus.prog_ct), 'h3F0);
    bus.br_taken = 1'b1; step(1); clr_br();
    cmp("t2_plain_taken", int'(bus.prog_ct), 'h3F1);
    step(1);
    bus.br_taken = 1'b1; bus.br_rel = 1'b1; bus.br_off = 6'b111101; step(1); clr_br();
    cmp("t2_rel", int'(bus.prog_ct), 'h3EF);
    cmp("t2_nowrap", int'(bus.wrap_err), 0);
    bus.br_taken = 1'b1; bus.br_abs = 1'b1; bus.br_rel = 1'b1;
    bus.br_target = 10'h3FE; bus.br_off = 6'd5; step(1); clr_br();
    cmp("t3_abs_wins", int'(bus.prog_ct), 'h3FE);

    // T3: increment past all-ones
    step(1);
    cmp("t3_pc3ff", int'(bus.prog_ct), 'h3FF);
    step(1);
    cmp("t3_pc0", int'(bus.prog_ct), 0);
    cmp("t3_wrap", int'(bus.wrap_err), 1);
    step(3);
    bus.br_taken = 1'b1; bus.br_rel = 1'b1; bus.br_off = 6'b111011; step(1); clr_br();
    cmp("t3_borrow_pc", int'(bus.prog_ct), 'h3FE);
    bus.start = 1'b1; step(1);
    cmp("t3_wrap_sticky", int'(bus.wrap_err), 1);
    step(1);
    cmp("t3_wrap_clr", int'(bus.wrap_err), 0);

    // T4: stall with a branch pending
    bus.start = 1'b0; step(1);
    step(5);
    cmp("t4_pc5", int'(bus.prog_ct), 5);
    bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_abs = 1'b1; bus.br_target = 10'h100;
    step(3); clr_br();
    cmp("t4_stall_pc", int'(bus.prog_ct), 5);
    cmp("t4_stall_cyc", int'(bus.cyc_cnt), 8);
    step(1);
    cmp("t4_pc6", int'(bus.prog_ct), 6);
    bus.br_taken = 1'b1; bus.br_rel = 1'b1; bus.br_off = 6'b111001; step(1); clr_br();
    cmp("t4_borrow_pc", int'(bus.prog_ct), 'h3FF);
    cmp("t4_borrow_wrap", int'(bus.wrap_err), 1);

    // T5: restart mid-run, then asynchronous reset mid-run
    bus.start = 1'b1; step(2);
    cmp("t5_cyc_clr", int'(bus.cyc_cnt), 0);
    bus.start = 1'b0; step(1);
    step(7);
    cmp("t5_pc7", int'(bus.prog_ct), 7);
    bus.start = 1'b1; step(1);
    cmp("t5_restart_pc", int'(bus.prog_ct), START);
    cmp("t5_restart_run", int'(bus.running), 0);
    step(1);
    bus.start = 1'b0; step(1);
    step(3);
    cmp("t5_pc3", int'(bus.prog_ct), 3);
    #1 reset = 1'b1;
    #1;
    cmp("t5_areset_pc", int'(bus.prog_ct), START);
    cmp("t5_areset_run", int'(bus.running), 0);
    cmp("t5_areset_cyc", int'(bus.cyc_cnt), 0);
    step(1);
    reset = 1'b0;
    step(3);
    cmp("t5_post_reset_idle", int'(bus.running), 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
